// File: rtl/mux_stim_gen.sv
// Pseudo-random stimulus source for the MUX2_1 in1/in2/sel inputs.
// A 16-bit Fibonacci LFSR is stepped once every INTERVAL clocks while a run is active.
module mux_stim_gen #(
    parameter int          INTERVAL  = 10,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          UPD_CNT_W = 16
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 seed_load,
    input  logic [15:0]          seed_in,
    input  logic [UPD_CNT_W-1:0] num_upd,
    output logic                 in1,
    output logic                 in2,
    output logic                 sel,
    output logic                 upd_valid,
    output logic                 busy,
    output logic                 done,
    output logic [UPD_CNT_W-1:0] upd_count
);

    localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [15:0]          lfsrNext;
    logic [15:0]          seedSafe;
    logic [CNT_W-1:0]     intervalCnt_q, intervalCnt_d;
    logic [UPD_CNT_W-1:0] updCount_q, updCount_d;
    logic [UPD_CNT_W-1:0] updInc;
    logic [UPD_CNT_W-1:0] numUpd_q, numUpd_d;
    logic                 in1_q, in1_d;
    logic                 in2_q, in2_d;
    logic                 sel_q, sel_d;
    logic                 updValid_q, updValid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // Taps 16,14,13,11; an all-zero seed would lock the LFSR, so it is replaced by SEED.
    assign lfsrNext = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign seedSafe = (seed_in == 16'h0000) ? SEED : seed_in;
    assign updInc   = updCount_q + UPD_CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_q;
        intervalCnt_d = intervalCnt_q;
        updCount_d    = updCount_q;
        numUpd_d      = numUpd_q;
        in1_d         = in1_q;
        in2_d         = in2_q;
        sel_d         = sel_q;
        updValid_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (seed_load) begin
                    lfsr_d = seedSafe;
                end
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d       = RUN;
                    intervalCnt_d = '0;
                    updCount_d    = '0;
                    numUpd_d      = num_upd;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (intervalCnt_q == CNT_LAST) begin
                    intervalCnt_d = '0;
                    lfsr_d        = lfsrNext;
                    in1_d         = lfsrNext[0];
                    in2_d         = lfsrNext[5];
                    sel_d         = lfsrNext[10];
                    updValid_d    = 1'b1;
                    updCount_d    = updInc;
                    if ((numUpd_q != '0) && (updInc == numUpd_q)) begin
                        state_d = DONE;
                    end
                end else begin
                    intervalCnt_d = intervalCnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            lfsr_q        <= SEED;
            intervalCnt_q <= '0;
            updCount_q    <= '0;
            numUpd_q      <= '0;
            in1_q         <= 1'b0;
            in2_q         <= 1'b0;
            sel_q         <= 1'b0;
            updValid_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            intervalCnt_q <= intervalCnt_d;
            updCount_q    <= updCount_d;
            numUpd_q      <= numUpd_d;
            in1_q         <= in1_d;
            in2_q         <= in2_d;
            sel_q         <= sel_d;
            updValid_q    <= updValid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign in1       = in1_q;
    assign in2       = in2_q;
    assign sel       = sel_q;
    assign upd_valid = updValid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign upd_count = updCount_q;

endmodule

// File: doc/mux_stim_gen.md
Name: mux_stim_gen

Overview:
- Synthesizable stimulus source placed directly upstream of the 2:1 mux (MUX2_1).
- Drives the mux's in1, in2 and sel inputs with pseudo-random levels from a 16-bit LFSR, refreshed every INTERVAL clocks.
- Replaces bench-only $random stimulus so the mux can be exercised on the FPGA. A counter can stop it after a programmed number of updates.

Parameters:
- INTERVAL, 10: clock cycles between updates; legal range >=1.
- SEED, 16'hACE1: LFSR value at reset; must be nonzero.
- UPD_CNT_W, 16: width of the update counter and of num_upd.

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- start  input  1  level, sampled each clock; begins a run from IDLE or DONE.
- stop  input  1  level; aborts a run and returns to IDLE.
- seed_load  input  1  loads seed_in into the LFSR (only in IDLE or DONE).
- seed_in  input  16  seed value for seed_load.
- num_upd  input  UPD_CNT_W  number of updates per run; 0 means unlimited. Sampled when start is accepted.
- in1  output  1  to mux in1.
- in2  output  1  to mux in2.
- sel  output  1  to mux sel.
- upd_valid  output  1  one-cycle pulse, coincident with the cycle in which in1/in2/sel take new values.
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE.
- upd_count  output  UPD_CNT_W  number of updates in the current run.

Behaviour:
- Reset (sys_rst=1 at an edge):
  - state=IDLE, lfsr=SEED.
  - in1, in2, sel, upd_valid, busy, done all 0.
  - upd_count=0, interval counter=0, latched num_upd=0.
  - Reset has priority over every other input and aborts a run in any state.
- LFSR:
  - Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - Advances exactly once per update and is otherwise frozen.
  - On update: in1 = next[0], in2 = next[5], sel = next[10], all registered.
- States:
  - IDLE:
    - stop has priority: if start and stop are both high, stay in IDLE.
    - If start=1 and stop=0: go to RUN; clear interval counter and upd_count; latch num_upd.
    - seed_load=1: lfsr <= seed_in, or SEED if seed_in==0 (the all-zero lock-up state is forbidden).
    - If seed_load and start are high together, the seed is loaded first, so the run uses the new seed.
  - RUN:
    - Interval counter counts 0..INTERVAL-1, then wraps.
    - When counter==INTERVAL-1: advance LFSR, update outputs, assert upd_valid for the next cycle, increment upd_count.
    - If latched num_upd!=0 and the incremented upd_count equals num_upd: go to DONE in the same edge.
    - stop=1: go to IDLE with no update on that edge, even if the counter is at INTERVAL-1.
    - start and seed_load are ignored in RUN.
  - DONE:
    - done=1 and busy=0.
    - seed_load behaves as in IDLE.
    - start: re-enter RUN, clearing upd_count and the interval counter; the LFSR continues from its current value.
    - stop: go to IDLE.
- Timing:
  - start high in cycle k: busy=1 from cycle k+1.
  - First upd_valid and first new outputs appear in cycle k+INTERVAL+1, then every INTERVAL cycles.
  - INTERVAL=1 gives an update every cycle.
- Output holding:
  - in1/in2/sel keep their last value through IDLE/DONE and across stop.
  - They return to 0 only on reset.
- Counter wrap: with num_upd=0, upd_count wraps from 2^UPD_CNT_W-1 to 0 and the run continues.
- busy, done and upd_valid are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset check: assert sys_rst 3 cycles -> in1=in2=sel=0, busy=done=upd_valid=0, upd_count=0.
- Default seed, num_upd=2, start pulsed in cycle k:
  - First update in cycle k+11 -> in1=1, in2=0, sel=0 (lfsr=16'h59C3).
  - Second update in cycle k+21 -> lfsr=16'hB387, in1=1, in2=0, sel=0.
  - done=1 from cycle k+21, no further upd_valid, upd_count=2.
- seed_load with seed_in=0 in IDLE, then start, num_upd=1 -> outputs identical to the first update of the default-seed case (SEED substituted).
- stop asserted in the same cycle the counter hits INTERVAL-1 -> no upd_valid, outputs unchanged, busy=0 next cycle, upd_count unchanged.
- start and stop both high in IDLE -> stays IDLE, busy=0. start held high in RUN -> no restart, upd_count keeps incrementing.
- INTERVAL=1, num_upd=0, run 2^UPD_CNT_W+3 cycles -> upd_valid high every cycle, upd_count wraps to 0 and continues. Also pulse sys_rst mid-run -> everything returns to its reset values the next cycle.
